// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter driven by codec-mastered BCLK/LRCLK.
// One-deep hold buffer feeds an MSB-first serializer on dacdat.
module i2s_tx #(
  parameter int K    = 24,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         bclk,
  input  logic         lrclk,
  input  logic [K-1:0] left_in,
  input  logic [K-1:0] right_in,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic         dacdat,
  output logic         next_lrclk_fall,
  output logic         underrun
);

  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_e;

  state_e state_q, state_d;

  logic [SYNC-1:0] bclk_s_q, lrclk_s_q;
  logic            bclk_e_q, lrclk_e_q;
  logic            bf, lf, lr;

  logic [K-1:0] hold_l_q, hold_l_d;
  logic [K-1:0] hold_r_q, hold_r_d;
  logic [K-1:0] act_l_q, act_l_d;
  logic [K-1:0] act_r_q, act_r_d;
  logic [K-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         hold_full_q, hold_full_d;
  logic         dac_q, dac_d;
  logic         und_q, und_d;
  logic         nlf_q, nlf_d;
  logic         accept;
  logic         shift_en;

  assign bf = bclk_e_q & ~bclk_s_q[SYNC-1];
  assign lf = lrclk_e_q & ~lrclk_s_q[SYNC-1];
  assign lr = ~lrclk_e_q & lrclk_s_q[SYNC-1];

  assign sample_ready    = ~hold_full_q;
  assign dacdat          = dac_q;
  assign next_lrclk_fall = nlf_q;
  assign underrun        = und_q;

  // Resynchronize codec clocks, one extra stage for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_s_q  <= '0;
      lrclk_s_q <= '0;
      bclk_e_q  <= 1'b0;
      lrclk_e_q <= 1'b0;
    end else begin
      bclk_s_q  <= (bclk_s_q << 1) | SYNC'(bclk);
      lrclk_s_q <= (lrclk_s_q << 1) | SYNC'(lrclk);
      bclk_e_q  <= bclk_s_q[SYNC-1];
      lrclk_e_q <= lrclk_s_q[SYNC-1];
    end
  end

  // Hold buffer handshake, frame-start transfer and pulses
  always_comb begin
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    und_d       = 1'b0;
    nlf_d       = lf;
    accept      = sample_valid & ~hold_full_q;
    if (lf) begin
      if (hold_full_q) begin
        act_l_d     = hold_l_q;
        act_r_d     = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        und_d = (state_q != IDLE);
      end
    end
    if (accept) begin
      hold_l_d    = left_in;
      hold_r_d    = right_in;
      hold_full_d = 1'b1;
    end
  end

  // Slot sequencing and serializer
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    dac_d    = dac_q;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        dac_d = 1'b0;
        if (lf) begin
          state_d = LEFT;
          sh_d    = hold_full_q ? hold_l_q : act_l_q;
          cnt_d   = '0;
        end
      end
      LEFT: begin
        if (lr) begin
          state_d = RIGHT;
          sh_d    = act_r_q;
          cnt_d   = '0;
        end else begin
          shift_en = bf;
        end
      end
      RIGHT: begin
        if (lf) begin
          state_d = LEFT;
          sh_d    = hold_full_q ? hold_l_q : act_l_q;
          cnt_d   = '0;
        end else begin
          shift_en = bf;
        end
      end
      default: state_d = IDLE;
    endcase
    if (shift_en) begin
      if (cnt_q < CW'(K)) begin
        dac_d = sh_q[K-1];
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CW'(1);
      end else begin
        dac_d = 1'b0;
      end
    end
    if (!ena) begin
      state_d = IDLE;
      dac_d   = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      act_l_q     <= '0;
      act_r_q     <= '0;
      sh_q        <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      dac_q       <= 1'b0;
      und_q       <= 1'b0;
      nlf_q       <= 1'b0;
    end else begin
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      dac_q       <= dac_d;
      und_q       <= und_d;
      nlf_q       <= nlf_d;
    end
  end

endmodule
